// File: rtl/axis_frame_capture.sv
// rtl/axis_frame_capture.sv - AXI-Stream single-frame capture sink with framing checks and a registered read port
module axis_frame_capture #(
    parameter int WIDTH      = 128,
    parameter int HEIGHT     = 100,
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = $clog2(WIDTH * HEIGHT),
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    input  logic                  arm,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   pix_count,
    output logic [15:0]           frame_count,
    output logic                  err_short,
    output logic                  err_long,
    output logic                  err_sof
);

    localparam int                N        = WIDTH * HEIGHT;
    localparam logic [ADDR_WIDTH:0] DEPTH    = (ADDR_WIDTH + 1)'(N);
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(N - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_WIDTH-1:0] ram [0:N-1];

    logic                  accept;
    logic                  rearm;
    logic                  wr_en;
    logic [ADDR_WIDTH:0]   beat_idx;
    logic                  beat_last;
    logic                  frame_end;

    assign accept = s_axis_tvalid && s_axis_tready;

    // A SOF beat always lands at address 0, both when first seen and as a mid-frame restart.
    assign beat_idx  = ((state == WAIT_SOF) || s_axis_tuser) ? '0 : pix_count;
    assign beat_last = (beat_idx == LAST_IDX);
    assign frame_end = accept && (s_axis_tlast || beat_last);

    assign wr_en = accept && ((state == CAPTURE) || ((state == WAIT_SOF) && s_axis_tuser));
    assign rearm = (((state == IDLE) || (state == DONE)) && arm) || ((state == DONE) && CONTINUOUS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (arm) begin
                    next_state = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (accept && s_axis_tuser) begin
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (frame_end) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (CONTINUOUS || arm) begin
                    next_state = WAIT_SOF;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            WAIT_SOF: busy = 1'b1;
            CAPTURE:  busy = 1'b1;
            DONE:     done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Registered from next_state so tready drops in the same cycle DONE is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axis_tready <= 1'b0;
        end else begin
            s_axis_tready <= (next_state == WAIT_SOF) || (next_state == CAPTURE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_count <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            err_sof   <= 1'b0;
        end else if (rearm) begin
            pix_count <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            err_sof   <= 1'b0;
        end else if (wr_en) begin
            pix_count <= beat_idx + 1'b1;
            if (state == CAPTURE) begin
                if (s_axis_tuser) begin
                    err_sof <= 1'b1;
                end
                if (s_axis_tlast && !beat_last) begin
                    err_short <= 1'b1;
                end
                if (beat_last && !s_axis_tlast) begin
                    err_long <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
        end else if ((state == CAPTURE) && (next_state == DONE)) begin
            frame_count <= frame_count + 16'd1;
        end
    end

    // Frame storage is deliberately not reset so a capture survives a later reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[beat_idx[ADDR_WIDTH-1:0]] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < DEPTH) begin
            rd_data <= ram[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_axis_frame_capture.sv
// tb/tb_axis_frame_capture.sv - scoreboard bench for axis_frame_capture
`timescale 1ns/1ps
module tb_axis_frame_capture;

    localparam int N  = 12800;
    localparam int CN = 32;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [23:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tuser, m_tready, m_arm;
    logic [13:0] m_rd_addr;
    logic [23:0] m_rd_data;
    logic        m_busy, m_done, m_err_short, m_err_long, m_err_sof;
    logic [14:0] m_pix_count;
    logic [15:0] m_frame_count;

    logic [23:0] c_tdata;
    logic        c_tvalid, c_tlast, c_tuser, c_tready, c_arm;
    logic [4:0]  c_rd_addr;
    logic [23:0] c_rd_data;
    logic        c_busy, c_done, c_err_short, c_err_long, c_err_sof;
    logic [5:0]  c_pix_count;
    logic [15:0] c_frame_count;

    logic [23:0] ref_mem [N];
    logic [23:0] c_ref [CN];
    logic [23:0] exp_q [$];
    logic [15:0] fc_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_fc = 16'd0;

    always #5 clk = ~clk;

    axis_frame_capture dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(m_tdata), .s_axis_tvalid(m_tvalid), .s_axis_tlast(m_tlast),
        .s_axis_tuser(m_tuser), .s_axis_tready(m_tready), .arm(m_arm),
        .rd_addr(m_rd_addr), .rd_data(m_rd_data), .busy(m_busy), .done(m_done),
        .pix_count(m_pix_count), .frame_count(m_frame_count),
        .err_short(m_err_short), .err_long(m_err_long), .err_sof(m_err_sof)
    );

    axis_frame_capture #(.WIDTH(8), .HEIGHT(4), .CONTINUOUS(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(c_tdata), .s_axis_tvalid(c_tvalid), .s_axis_tlast(c_tlast),
        .s_axis_tuser(c_tuser), .s_axis_tready(c_tready), .arm(c_arm),
        .rd_addr(c_rd_addr), .rd_data(c_rd_data), .busy(c_busy), .done(c_done),
        .pix_count(c_pix_count), .frame_count(c_frame_count),
        .err_short(c_err_short), .err_long(c_err_long), .err_sof(c_err_sof)
    );

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input bit which, input logic [23:0] d, input bit u, input bit l);
        bit rdy;
        int waits;
        waits = 0;
        if (which) begin
            c_tdata = d; c_tuser = u; c_tlast = l; c_tvalid = 1'b1;
        end else begin
            m_tdata = d; m_tuser = u; m_tlast = l; m_tvalid = 1'b1;
        end
        while (1) begin
            rdy = which ? c_tready : m_tready;
            idle_cycle();
            if (rdy) break;
            waits++;
            if (waits > 64) begin
                n_vec++; n_err++;
                $display("FAIL tready_timeout: tready stayed 0 for %0d cycles, required 1", waits);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $fatal(1, "stream stalled");
            end
        end
        if (which) c_tvalid = 1'b0;
        else       m_tvalid = 1'b0;
    endtask

    task automatic pulse_arm(input bit which);
        if (which) c_arm = 1'b1; else m_arm = 1'b1;
        idle_cycle();
        c_arm = 1'b0;
        m_arm = 1'b0;
    endtask

    task automatic send_main_frame(input logic [23:0] base, input int n, input int last_at,
                                   input bit gaps, input int arm_at);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(3) == 0) idle_cycle();
            if (i == arm_at) m_arm = 1'b1;
            send_beat(1'b0, base + 24'(i), i == 0, i == last_at);
            m_arm = 1'b0;
            ref_mem[i] = base + 24'(i);
        end
    endtask

    task automatic read_check(input int a);
        logic [23:0] e;
        m_rd_addr = 14'(a);
        if (a < N) exp_q.push_back(ref_mem[a]);
        else       exp_q.push_back(24'h0);
        idle_cycle();
        e = exp_q.pop_front();
        n_vec++;
        if (m_rd_data !== e) begin
            n_err++;
            $display("FAIL rd_data[%0d]: got %h, expected %h", a, m_rd_data, e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) idle_cycle();
        n_vec++;
        if ({m_tready, m_busy, m_done, m_err_short, m_err_long, m_err_sof} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b, expected 000000",
                     {m_tready, m_busy, m_done, m_err_short, m_err_long, m_err_sof});
        end
        n_vec++;
        if (m_pix_count !== 15'd0 || m_frame_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_counts: got pix=%0d frames=%0d, expected 0 0", m_pix_count, m_frame_count);
        end
        n_vec++;
        if (m_rd_data !== 24'h0 || c_rd_data !== 24'h0) begin
            n_err++;
            $display("FAIL reset_rd_data: got %h/%h, expected 0", m_rd_data, c_rd_data);
        end
        n_vec++;
        if ({c_tready, c_busy, c_done} !== 3'b0 || c_frame_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_cont: got flags=%b frames=%0d, expected 0", {c_tready, c_busy, c_done}, c_frame_count);
        end
        rst_n = 1'b1;
        idle_cycle();
    endtask

    task automatic test_ramp_frame();
        m_arm = 1'b1;
        n_vec++;
        if (m_tready !== 1'b0) begin
            n_err++;
            $display("FAIL tready_before_arm: got %b, expected 0", m_tready);
        end
        idle_cycle();
        m_arm = 1'b0;
        n_vec++;
        if (m_tready !== 1'b1 || m_busy !== 1'b1) begin
            n_err++;
            $display("FAIL arm_response: got tready=%b busy=%b, expected 1 1", m_tready, m_busy);
        end
        send_main_frame(24'h0, N, N - 1, 1'b0, -1);
        exp_fc++;
        n_vec++;
        if ({m_done, m_busy, m_tready, m_err_short, m_err_long, m_err_sof} !== 6'b100000) begin
            n_err++;
            $display("FAIL ramp_flags: got %b, expected 100000",
                     {m_done, m_busy, m_tready, m_err_short, m_err_long, m_err_sof});
        end
        n_vec++;
        if (m_pix_count !== 15'd12800 || m_frame_count !== exp_fc) begin
            n_err++;
            $display("FAIL ramp_counts: got pix=%0d frames=%0d, expected 12800 %0d", m_pix_count, m_frame_count, exp_fc);
        end
        read_check(5000);
        n_vec++;
        if (m_rd_data !== 24'h001388) begin
            n_err++;
            $display("FAIL rd_5000: got %h, expected 001388", m_rd_data);
        end
        read_check(0);
        read_check(N - 1);
        read_check(N);
        read_check(16383);
    endtask

    task automatic test_sof_restart();
        pulse_arm(1'b0);
        for (int j = 0; j < 50; j++) begin
            send_beat(1'b0, 24'hA00000 + 24'(j), j == 0, 1'b0);
            ref_mem[j] = 24'hA00000 + 24'(j);
        end
        send_main_frame(24'h100000, N, N - 1, 1'b0, -1);
        exp_fc++;
        n_vec++;
        if ({m_done, m_err_short, m_err_long, m_err_sof} !== 4'b1001) begin
            n_err++;
            $display("FAIL sof_flags: got %b, expected 1001", {m_done, m_err_short, m_err_long, m_err_sof});
        end
        n_vec++;
        if (m_pix_count !== 15'd12800 || m_frame_count !== exp_fc) begin
            n_err++;
            $display("FAIL sof_counts: got pix=%0d frames=%0d, expected 12800 %0d", m_pix_count, m_frame_count, exp_fc);
        end
        read_check(0);
        read_check(49);
        read_check(50);
        read_check(N - 1);
    endtask

    task automatic test_sof_eof();
        pulse_arm(1'b0);
        for (int j = 0; j < 10; j++) begin
            send_beat(1'b0, 24'hB00000 + 24'(j), j == 0, 1'b0);
            ref_mem[j] = 24'hB00000 + 24'(j);
        end
        send_beat(1'b0, 24'hB0FFFF, 1'b1, 1'b1);
        ref_mem[0] = 24'hB0FFFF;
        exp_fc++;
        n_vec++;
        if ({m_done, m_err_short, m_err_long, m_err_sof} !== 4'b1101 || m_pix_count !== 15'd1) begin
            n_err++;
            $display("FAIL sof_eof: got flags=%b pix=%0d, expected 1101 1",
                     {m_done, m_err_short, m_err_long, m_err_sof}, m_pix_count);
        end
        read_check(0);
        read_check(9);
    endtask

    task automatic test_gaps();
        pulse_arm(1'b0);
        for (int k = 0; k < 3; k++) send_beat(1'b0, 24'hDEAD00 + 24'(k), 1'b0, 1'b0);
        n_vec++;
        if (m_pix_count !== 15'd0 || m_busy !== 1'b1) begin
            n_err++;
            $display("FAIL junk_discard: got pix=%0d busy=%b, expected 0 1", m_pix_count, m_busy);
        end
        send_main_frame(24'h0, N, N - 1, 1'b1, 6000);
        exp_fc++;
        n_vec++;
        if ({m_done, m_err_short, m_err_long, m_err_sof} !== 4'b1000 || m_pix_count !== 15'd12800) begin
            n_err++;
            $display("FAIL gaps_status: got flags=%b pix=%0d, expected 1000 12800",
                     {m_done, m_err_short, m_err_long, m_err_sof}, m_pix_count);
        end
        n_vec++;
        if (m_frame_count !== exp_fc) begin
            n_err++;
            $display("FAIL gaps_frames: got %0d, expected %0d", m_frame_count, exp_fc);
        end
        for (int a = 0; a < N; a++) read_check(a);
    endtask

    task automatic test_short();
        pulse_arm(1'b0);
        send_main_frame(24'h0, 100, 99, 1'b0, -1);
        exp_fc++;
        n_vec++;
        if ({m_done, m_tready, m_err_short, m_err_long, m_err_sof} !== 5'b10100 || m_pix_count !== 15'd100) begin
            n_err++;
            $display("FAIL short_status: got flags=%b pix=%0d, expected 10100 100",
                     {m_done, m_tready, m_err_short, m_err_long, m_err_sof}, m_pix_count);
        end
        m_tdata = 24'hFFFFFF; m_tuser = 1'b1; m_tlast = 1'b0; m_tvalid = 1'b1;
        repeat (4) idle_cycle();
        m_tvalid = 1'b0;
        n_vec++;
        if (m_pix_count !== 15'd100 || m_frame_count !== exp_fc || m_done !== 1'b1) begin
            n_err++;
            $display("FAIL short_blocked: got pix=%0d frames=%0d done=%b, expected 100 %0d 1",
                     m_pix_count, m_frame_count, m_done, exp_fc);
        end
        read_check(0);
    endtask

    task automatic test_long();
        pulse_arm(1'b0);
        send_main_frame(24'h0, N, -1, 1'b0, -1);
        exp_fc++;
        n_vec++;
        if ({m_done, m_err_short, m_err_long, m_err_sof} !== 4'b1010 || m_pix_count !== 15'd12800) begin
            n_err++;
            $display("FAIL long_status: got flags=%b pix=%0d, expected 1010 12800",
                     {m_done, m_err_short, m_err_long, m_err_sof}, m_pix_count);
        end
        n_vec++;
        if (m_frame_count !== exp_fc) begin
            n_err++;
            $display("FAIL long_frames: got %0d, expected %0d", m_frame_count, exp_fc);
        end
        pulse_arm(1'b0);
        n_vec++;
        if ({m_err_long, m_done, m_busy, m_tready} !== 4'b0011 || m_pix_count !== 15'd0) begin
            n_err++;
            $display("FAIL rearm_clear: got flags=%b pix=%0d, expected 0011 0",
                     {m_err_long, m_done, m_busy, m_tready}, m_pix_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] efc;
        logic [23:0] e;
        pulse_arm(1'b1);
        for (int f = 0; f < 3; f++) begin
            fc_q.push_back(16'(f + 1));
            for (int p = 0; p < CN; p++) begin
                send_beat(1'b1, 24'h0C0000 + 24'(f * 256 + p), p == 0, p == CN - 1);
                c_ref[p] = 24'h0C0000 + 24'(f * 256 + p);
            end
            efc = fc_q.pop_front();
            n_vec++;
            if (c_done !== 1'b1 || c_frame_count !== efc || c_pix_count !== 6'd32) begin
                n_err++;
                $display("FAIL cont_done[%0d]: got done=%b frames=%0d pix=%0d, expected 1 %0d 32",
                         f, c_done, c_frame_count, c_pix_count, efc);
            end
            idle_cycle();
            n_vec++;
            if (c_done !== 1'b0 || c_busy !== 1'b1 || c_tready !== 1'b1 || c_pix_count !== 6'd0) begin
                n_err++;
                $display("FAIL cont_rearm[%0d]: got done=%b busy=%b tready=%b pix=%0d, expected 0 1 1 0",
                         f, c_done, c_busy, c_tready, c_pix_count);
            end
        end
        for (int p = 0; p < 5; p++) begin
            send_beat(1'b1, 24'h0C0300 + 24'(p), p == 0, 1'b0);
            c_ref[p] = 24'h0C0300 + 24'(p);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({c_tready, c_busy, c_done} !== 3'b0 || c_frame_count !== 16'd0 || c_pix_count !== 6'd0) begin
            n_err++;
            $display("FAIL cont_reset: got flags=%b frames=%0d pix=%0d, expected 000 0 0",
                     {c_tready, c_busy, c_done}, c_frame_count, c_pix_count);
        end
        idle_cycle();
        rst_n = 1'b1;
        c_rd_addr = 5'd10;
        exp_q.push_back(c_ref[10]);
        idle_cycle();
        e = exp_q.pop_front();
        n_vec++;
        if (c_rd_data !== e) begin
            n_err++;
            $display("FAIL cont_ram_kept[10]: got %h, expected %h", c_rd_data, e);
        end
        c_rd_addr = 5'd2;
        exp_q.push_back(c_ref[2]);
        idle_cycle();
        e = exp_q.pop_front();
        n_vec++;
        if (c_rd_data !== e) begin
            n_err++;
            $display("FAIL cont_ram_kept[2]: got %h, expected %h", c_rd_data, e);
        end
    endtask

    initial begin
        m_tdata = '0; m_tvalid = 1'b0; m_tlast = 1'b0; m_tuser = 1'b0; m_arm = 1'b0; m_rd_addr = '0;
        c_tdata = '0; c_tvalid = 1'b0; c_tlast = 1'b0; c_tuser = 1'b0; c_arm = 1'b0; c_rd_addr = '0;
        test_reset();
        test_ramp_frame();
        test_sof_restart();
        test_sof_eof();
        test_gaps();
        test_short();
        test_long();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
